serial_subtractor: RTL
======================

Name: serial_subtractor

Overview:
- Bit-serial, multi-cycle subtractor. It computes ans = inA - inB one bit per clock, LSB first, and reports the final borrow.
- It is the inverse-direction companion to the team's combinational adder: same operand and result naming, now with a start/busy/done handshake.
- It sits on the datapath as a small arithmetic unit driven by a controller or a bench.

Parameters:
W, 5, operand and result width in bits (W >= 2)
CW, 3, width of the bit counter; must satisfy 2**CW > W

Ports:
clk  input  1  sole clock; all state changes on the rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request; sampled only when the block can accept (IDLE or DONE)
inA  input  W  minuend; latched on the accepted start
inB  input  W  subtrahend; latched on the accepted start
busy  output  1  high while a subtraction is in progress (RUN)
done  output  1  single-cycle pulse; ans and borrow are valid in that cycle
ans  output  W  result inA - inB, modulo 2**W
borrow  output  1  final borrow out; 1 exactly when inA < inB (unsigned)

Behaviour:
- Reset (synchronous, active-high): state=IDLE, ans=0, borrow=0, busy=0, done=0. Counter, operand and borrow registers are cleared.
- Reset asserted mid-operation aborts the computation. The partial result is discarded and ans stays 0 after reset.
- Three states:
  - IDLE: busy=0, done=0. If start=1, latch inA/inB, clear counter and running borrow, go to RUN.
  - RUN: busy=1. Each cycle processes bit i = counter:
    - d = a[i] ^ b[i] ^ br
    - br_next = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br)
    - d shifts into the result register from the MSB end (shift right).
    - counter increments. When counter == W-1, go to DONE at the next edge.
  - DONE: done=1, busy=0. ans and borrow are updated on entry to DONE.
    - If start=1, latch new operands and go straight to RUN (back-to-back), else go to IDLE.
- Latency: start accepted at edge 0 gives busy=1 for cycles 1..W and done=1 in cycle W+1. Back-to-back throughput is one result per W+1 cycles.
- start during RUN is ignored; operands are not re-latched and the in-flight result is unaffected.
- inA/inB changes after the accepting edge have no effect.
- ans and borrow are registered. They hold the last completed result until the next DONE, and stay stable through IDLE and the following RUN.
- busy and done are never both 1. done is high for exactly one cycle per accepted start.
- Width rule: the result is modulo 2**W, with no sign interpretation. Signed users take overflow from the operand MSBs externally.

Decomposition:
- Shared package holds:
  - state encoding constants IDLE=2'd0, RUN=2'd1, DONE=2'd2
  - the default width constant (5)
- One natural sub-module: full_subtractor (inputs a, b, bin; outputs d, bout; purely combinational). It is instantiated once in the RUN datapath.
- Counter, shift register and FSM live in serial_subtractor.

Test Plan:
1. W=5, reset 2 cycles, then start pulse with inA=3, inB=2 → busy for 5 cycles; done in cycle 6; ans=1, borrow=0; ans held at 1 until the next done.
2. inA=2, inB=3 → ans=5'd31, borrow=1. inA=0, inB=31 → ans=1, borrow=1. inA=31, inB=31 → ans=0, borrow=0.
3. start held high continuously with inA=10, inB=4 then inA=4, inB=10 (switched at the DONE cycle) → done pulses at cycles 6 and 12; results 6/borrow 0, then 26/borrow 1.
4. Accept inA=7, inB=1, then pulse start with inA=0, inB=1 during cycle 3 of RUN → ignored; done once with ans=6, borrow=0, no extra done.
5. Accept inA=9, inB=5, assert reset in cycle 3 for one cycle → next edge: busy=0, done=0, ans=0, borrow=0; no done ever appears for the aborted operation.
6. Change inA/inB every cycle during RUN after accepting inA=20, inB=8 → ans=12, borrow=0. No X on any output after reset release.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: widths, state encoding
// and the single-bit borrow equation.
package serial_subtractor_pkg;

    localparam int unsigned DEF_W  = 5;
    localparam int unsigned DEF_CW = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Borrow out of one bit position of a - b - bin.
    function automatic logic fs_borrow(input logic a, input logic b, input logic bin);
        return (~a & b) | (~(a ^ b) & bin);
    endfunction

endpackage : serial_subtractor_pkg

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit combinational full subtractor: d = a - b - bin, bout = borrow out.
module full_subtractor
    import serial_subtractor_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = fs_borrow(a, b, bin);

endmodule : full_subtractor

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: ans = inA - inB, LSB first, one bit per clock, with a
// start/busy/done handshake. The minuend register doubles as the result shifter.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int unsigned W  = DEF_W,
    parameter int unsigned CW = DEF_CW
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] inA,
    input  logic [W-1:0] inB,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] ans,
    output logic         borrow
);

    if (W < 2 || (2 ** CW) <= W) begin : g_param_check
        $error("serial_subtractor: need W >= 2 and 2**CW > W");
    end

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic           br_q, br_d;
    logic [W-1:0]   ans_q, ans_d;
    logic           borrow_q, borrow_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic           accept_c;
    logic           last_c;
    logic           d_c;
    logic           bout_c;

    assign accept_c = start && (state_q == IDLE || state_q == DONE);
    assign last_c   = (cnt_q == CW'(W - 1));

    full_subtractor u_fs (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .bin  (br_q),
        .d    (d_c),
        .bout (bout_c)
    );

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            br_q     <= 1'b0;
            ans_q    <= '0;
            borrow_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            br_q     <= br_d;
            ans_q    <= ans_d;
            borrow_q <= borrow_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_c) state_d = DONE;
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand shifting: each RUN cycle consumes bit 0 of a/b and pushes the
    // difference bit into the MSB of a, so a holds the result after W cycles.
    always_comb begin
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        br_d     = br_q;
        ans_d    = ans_q;
        borrow_d = borrow_q;
        if (accept_c) begin
            a_d   = inA;
            b_d   = inB;
            cnt_d = '0;
            br_d  = 1'b0;
        end else if (state_q == RUN) begin
            a_d   = {d_c, a_q[W-1:1]};
            b_d   = {1'b0, b_q[W-1:1]};
            br_d  = bout_c;
            cnt_d = cnt_q + CW'(1);
            if (last_c) begin
                ans_d    = {d_c, a_q[W-1:1]};
                borrow_d = bout_c;
            end
        end
    end

    // Handshake outputs, registered from the next state.
    always_comb begin
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign ans    = ans_q;
    assign borrow = borrow_q;

endmodule : serial_subtractor
